sram_mem_controller: RTL and testbench

Memory-stage controller between the MEM pipeline register and an external 16-bit asynchronous SRAM. It replaces the single-cycle byte-array data memory for large data sets. Each 32-bit load/store becomes two 16-bit SRAM transactions with programmable wait states. While an access is in progress, `ready` is held low so the hazard/freeze logic stalls the pipeline.

---
 rtl/sram_mem_controller_pkg.sv | 15 +
 rtl/sram_mem_controller.sv | 121 ++++++++++++
 tb/tb_sram_mem_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states,
// SRAM data width and the default CPU base address of SRAM word 0.
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int SRAM_DATA_W       = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit load/store into two wait-stated 16-bit asynchronous SRAM
// transactions and holds ready low so the pipeline freezes until completion.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int IDX_W = SRAM_ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       data_q, data_d;

  logic request;
  logic upper_phase;
  logic phase_last;

  assign request     = mem_r_en | mem_w_en;
  assign upper_phase = (state_q == ST_HIGH);
  assign phase_last  = (cnt_q == CNT_LAST);

  // Both enables high counts as a store, so the load register is left alone.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    is_store_d  = is_store_q;
    data_d      = data_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          idx_d      = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
          wdata_d    = write_data;
          is_store_d = mem_w_en;
          cnt_d      = '0;
          state_d    = ST_LOW;
        end
      end
      ST_LOW, ST_HIGH: begin
        sram_addr = {idx_q, upper_phase};
        if (is_store_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = upper_phase ? wdata_q[31:16] : wdata_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(1);
        // Read data is captured on the last wait cycle, once the SRAM has settled.
        if (phase_last) begin
          cnt_d = '0;
          if (!is_store_q) begin
            if (upper_phase) data_d[31:16] = sram_dq_in;
            else             data_d[15:0]  = sram_dq_in;
          end
          state_d = upper_phase ? ST_DONE : ST_HIGH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      data_q     <= data_d;
    end
  end

  assign ready     = ((state_q == ST_IDLE) && !request) || (state_q == ST_DONE);
  assign data      = data_q;
  assign sram_ce_n = reset;
  assign sram_ub_n = reset;
  assign sram_lb_n = reset;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: behavioural SRAM plus a
// word-level reference memory that predicts load results and bus timing.
module tb_sram_mem_controller;

  localparam int W     = 2;
  localparam int BASE  = 1024;
  localparam int AW    = 18;
  localparam int N_CYC = 2 * W + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   address, write_data;
  logic [31:0]   data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;
  logic          sram_ce_n, sram_ub_n, sram_lb_n;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [31:0] ref_word [int];
  logic [31:0] exp_data;

  logic          obs_ready [0:N_CYC-1];
  logic [AW-1:0] obs_addr  [0:N_CYC-1];
  logic          obs_we_n  [0:N_CYC-1];
  logic          obs_oe_n  [0:N_CYC-1];
  logic          obs_dqoe  [0:N_CYC-1];
  logic [15:0]   obs_dqout [0:N_CYC-1];
  logic [31:0]   obs_data  [0:N_CYC-1];

  sram_mem_controller #(
    .BASE_ADDR  (BASE),
    .SRAM_ADDR_W(AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .write_data (write_data),
    .data       (data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM: reads follow the address while OE_n is low.
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

  always @(posedge clock) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'(BASE)) / 4) % (1 << (AW - 1)));
  endfunction

  function automatic logic [31:0] ref_read(input int i);
    return ref_word.exists(i) ? ref_word[i] : 32'h0;
  endfunction

  function automatic bit in_phase(input int c);
    return (c >= 1) && (c <= 2 * W);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [31:0] a, input int c);
    if (!in_phase(c)) return '0;
    return AW'(widx(a) * 2 + (c - 1) / W);
  endfunction

  function automatic logic [15:0] exp_dqout(input logic [31:0] wd, input int c);
    logic [31:0] v;
    v = wd;
    if (!in_phase(c)) return 16'h0;
    return ((c - 1) / W == 0) ? v[15:0] : v[31:16];
  endfunction

  task automatic model_access(input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] wd);
    if (wr) ref_word[widx(a)] = wd;
    else if (rd) exp_data = ref_read(widx(a));
  endtask

  // Drives one request from cycle 0 through DONE, recording every cycle.
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] a,
                            input logic [31:0] wd, input bit drop_early);
    mem_w_en   = wr;
    mem_r_en   = rd;
    address    = a;
    write_data = wd;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clock);
      obs_ready[c] = ready;
      obs_addr[c]  = sram_addr;
      obs_we_n[c]  = sram_we_n;
      obs_oe_n[c]  = sram_oe_n;
      obs_dqoe[c]  = sram_dq_oe;
      obs_dqout[c] = sram_dq_out;
      obs_data[c]  = data;
      @(posedge clock);
      #1;
      if (drop_early && c == 1) begin
        mem_w_en   = 1'b0;
        mem_r_en   = 1'b0;
        address    = $urandom;
        write_data = $urandom;
      end
    end
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'h0;
    write_data = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_compared++;
    if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
    n_compared++;
    if (data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_data got=%h exp=0", data); end
    n_compared++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
      n_mismatched++;
      $display("[TB] FAIL reset_strobes got we_n/oe_n/oe=%b%b%b exp=110", sram_we_n, sram_oe_n, sram_dq_oe);
    end
    n_compared++;
    if (sram_addr !== '0 || sram_dq_out !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_bus got addr=%h dq=%h exp=0/0", sram_addr, sram_dq_out);
    end
    n_compared++;
    if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b111) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ce got=%b%b%b exp=111", sram_ce_n, sram_ub_n, sram_lb_n);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    exp_data = 32'h0;
    @(negedge clock);
    n_compared++;
    if ({sram_ce_n, sram_ub_n, sram_lb_n, ready} !== 4'b0001) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_ce got ce/ub/lb/ready=%b%b%b%b exp=0001",
               sram_ce_n, sram_ub_n, sram_lb_n, ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_store;
    logic [31:0] a  = 32'd1032;
    logic [31:0] wd = 32'hDEADBEEF;
    run_access(1'b1, 1'b0, a, wd, 1'b0);
    model_access(1'b1, 1'b0, a, wd);
    for (int c = 0; c < N_CYC; c++) begin
      n_compared++;
      if (obs_ready[c] !== (c == 2 * W + 1)) begin
        n_mismatched++;
        $display("[TB] FAIL store_ready c=%0d got=%b exp=%b", c, obs_ready[c], c == 2 * W + 1);
      end
      n_compared++;
      if (obs_addr[c] !== exp_addr(a, c) || obs_dqout[c] !== exp_dqout(wd, c)) begin
        n_mismatched++;
        $display("[TB] FAIL store_bus c=%0d got addr=%0d dq=%h exp addr=%0d dq=%h",
                 c, obs_addr[c], obs_dqout[c], exp_addr(a, c), exp_dqout(wd, c));
      end
      n_compared++;
      if (obs_we_n[c] !== !in_phase(c) || obs_dqoe[c] !== in_phase(c) || obs_oe_n[c] !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL store_strobes c=%0d got we_n/oe/oe_n=%b%b%b exp=%b%b1",
                 c, obs_we_n[c], obs_dqoe[c], obs_oe_n[c], !in_phase(c), in_phase(c));
      end
    end
    @(negedge clock);
    n_compared++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL store_no_restart got ready=%b we_n=%b exp=1/1", ready, sram_we_n);
    end
    n_compared++;
    if (sram_mem[4] !== 16'hBEEF || sram_mem[5] !== 16'hDEAD) begin
      n_mismatched++;
      $display("[TB] FAIL store_sram got %h_%h exp DEAD_BEEF", sram_mem[5], sram_mem[4]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_load;
    logic [31:0] a = 32'd1032;
    logic [31:0] prev;
    prev = exp_data;
    run_access(1'b0, 1'b1, a, $urandom, 1'b0);
    model_access(1'b0, 1'b1, a, 32'h0);
    for (int c = 0; c < N_CYC; c++) begin
      n_compared++;
      if (obs_ready[c] !== (c == 2 * W + 1)) begin
        n_mismatched++;
        $display("[TB] FAIL load_ready c=%0d got=%b exp=%b", c, obs_ready[c], c == 2 * W + 1);
      end
      n_compared++;
      if (obs_addr[c] !== exp_addr(a, c) || obs_oe_n[c] !== !in_phase(c) ||
          obs_we_n[c] !== 1'b1 || obs_dqoe[c] !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL load_bus c=%0d got addr=%0d oe_n=%b we_n=%b oe=%b exp addr=%0d oe_n=%b we_n=1 oe=0",
                 c, obs_addr[c], obs_oe_n[c], obs_we_n[c], obs_dqoe[c], exp_addr(a, c), !in_phase(c));
      end
    end
    n_compared++;
    if (obs_data[W + 1] !== {prev[31:16], exp_data[15:0]}) begin
      n_mismatched++;
      $display("[TB] FAIL load_half_data got=%h exp=%h", obs_data[W + 1], {prev[31:16], exp_data[15:0]});
    end
    n_compared++;
    if (obs_data[2 * W + 1] !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL load_data got=%h exp=deadbeef", obs_data[2 * W + 1]);
    end
  endtask

  task automatic test_both_enables;
    logic [31:0] a = 32'd1036;
    run_access(1'b1, 1'b1, a, 32'h12345678, 1'b0);
    model_access(1'b1, 1'b1, a, 32'h12345678);
    n_compared++;
    if (obs_data[2 * W + 1] !== exp_data) begin
      n_mismatched++;
      $display("[TB] FAIL both_data got=%h exp=%h", obs_data[2 * W + 1], exp_data);
    end
    n_compared++;
    if (sram_mem[6] !== 16'h5678 || sram_mem[7] !== 16'h1234 || obs_we_n[1] !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL both_sram got %h_%h we_n=%b exp 1234_5678 we_n=0",
               sram_mem[7], sram_mem[6], obs_we_n[1]);
    end
  endtask

  task automatic test_reset_mid_store;
    mem_w_en   = 1'b1;
    address    = 32'd1032;
    write_data = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    mem_w_en = 1'b0;
    ref_word[2] = 32'hDEADF00D;
    exp_data    = 32'h0;
    @(negedge clock);
    n_compared++;
    if (ready !== 1'b1 || {sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110 || sram_addr !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_idle got ready=%b we_n/oe_n/oe=%b%b%b addr=%0d exp 1/110/0",
               ready, sram_we_n, sram_oe_n, sram_dq_oe, sram_addr);
    end
    n_compared++;
    if (data !== exp_data) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_data got=%h exp=%h", data, exp_data);
    end
    n_compared++;
    if (sram_mem[4] !== 16'hF00D || sram_mem[5] !== 16'hDEAD) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_sram got %h_%h exp DEAD_F00D", sram_mem[5], sram_mem[4]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d0, d1;
    logic        r_first_done;
    logic [31:0] data_first;
    d0 = $urandom;
    d1 = $urandom;
    run_access(1'b1, 1'b0, 32'd1024, d0, 1'b0);
    model_access(1'b1, 1'b0, 32'd1024, d0);
    run_access(1'b1, 1'b0, 32'd1028, d1, 1'b0);
    model_access(1'b1, 1'b0, 32'd1028, d1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    model_access(1'b0, 1'b1, 32'd1024, 32'h0);
    r_first_done = obs_ready[2 * W + 1];
    data_first   = obs_data[2 * W + 1];
    n_compared++;
    if (r_first_done !== 1'b1 || data_first !== exp_data) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first got ready=%b data=%h exp 1/%h", r_first_done, data_first, exp_data);
    end
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    model_access(1'b0, 1'b1, 32'd1028, 32'h0);
    n_compared++;
    if (obs_ready[0] !== 1'b0 || obs_oe_n[0] !== 1'b1 || obs_addr[0] !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_gap got ready=%b oe_n=%b addr=%0d exp 0/1/0", obs_ready[0], obs_oe_n[0], obs_addr[0]);
    end
    for (int c = 1; c < N_CYC; c++) begin
      n_compared++;
      if (obs_ready[c] !== (c == 2 * W + 1)) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_second_ready c=%0d got=%b exp=%b", c, obs_ready[c], c == 2 * W + 1);
      end
    end
    n_compared++;
    if (obs_data[2 * W + 1] !== exp_data) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second_data got=%h exp=%h", obs_data[2 * W + 1], exp_data);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int          op;
      bit          wr, rd, drop;
      logic [31:0] a, wd;
      op   = $urandom_range(0, 2);
      wr   = (op != 1);
      rd   = (op != 0);
      drop = 1'($urandom_range(0, 1));
      a    = 32'(BASE + 4 * $urandom_range(0, 7)) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      run_access(wr, rd, a, wd, drop);
      model_access(wr, rd, a, wd);
      for (int c = 0; c < N_CYC; c++) begin
        n_compared++;
        if (obs_ready[c] !== (c == 2 * W + 1) || obs_addr[c] !== exp_addr(a, c)) begin
          n_mismatched++;
          $display("[TB] FAIL rand_timing n=%0d c=%0d got ready=%b addr=%0d exp ready=%b addr=%0d",
                   n, c, obs_ready[c], obs_addr[c], c == 2 * W + 1, exp_addr(a, c));
        end
      end
      n_compared++;
      if (obs_data[2 * W + 1] !== exp_data) begin
        n_mismatched++;
        $display("[TB] FAIL rand_data n=%0d op=%0d addr=%0d got=%h exp=%h",
                 n, op, a, obs_data[2 * W + 1], exp_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting sram_mem_controller bench");
    test_reset();
    test_store();
    test_load();
    test_both_enables();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
